swipe_detector: RTL

Frame-rate motion stage placed directly downstream of the hue center-of-mass block. On each per-frame centroid update it computes the frame-to-frame velocity and keeps a short history of centroids for trail drawing. It also runs a gesture FSM that emits a one-cycle `swipe` pulse with a direction code. The game logic consumes `swipe` to trigger slicing; the display overlay consumes the history port.

---
 rtl/swipe_pkg.sv | 29 ++
 rtl/com_history.sv | 62 ++++++
 rtl/swipe_detector.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/swipe_pkg.sv
// Shared constants for the swipe detector: coordinate widths, FSM state
// encodings, direction codes and a small magnitude helper.
package swipe_pkg;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int VX_W  = X_W + 1;
  localparam int VY_W  = Y_W + 1;
  localparam int SPD_W = 12;
  localparam int RUN_W = 4;

  // Gesture FSM states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_TRACK    = 2'd1;
  localparam state_t ST_COOLDOWN = 2'd2;

  // Swipe direction codes (screen y grows downward).
  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  // Magnitude of a 12-bit two's complement value; inputs never reach -2048.
  function automatic logic [SPD_W-1:0] mag12(input logic [SPD_W-1:0] v);
    return v[SPD_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/com_history.sv
// Ring buffer of recent centroids for trail drawing. Written once per frame,
// read combinationally by age (0 = newest); entries beyond the fill level
// read back as zero with rd_ok_o low.
module com_history
  import swipe_pkg::*;
#(
  parameter int HIST_DEPTH = 8,
  localparam int AW = $clog2(HIST_DEPTH)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           wr_en_i,
  input  logic [X_W-1:0] wr_x_i,
  input  logic [Y_W-1:0] wr_y_i,
  input  logic [AW-1:0]  rd_age_i,
  output logic [X_W-1:0] rd_x_o,
  output logic [Y_W-1:0] rd_y_o,
  output logic           rd_ok_o
);

  localparam int FW = AW + 1;

  logic [X_W+Y_W-1:0] mem_q [HIST_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [AW-1:0]      rd_idx;
  logic [X_W+Y_W-1:0] rd_word;

  // Next pointer wraps naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + 1'b1;
    fill_d   = (fill_q == FW'(HIST_DEPTH)) ? fill_q : fill_q + 1'b1;
  end

  // Pointer and fill level; a frame coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (wr_en_i) begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is intentionally not cleared; fill_q gates what is visible.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !reset_i) begin
      mem_q[wr_ptr_q] <= {wr_x_i, wr_y_i};
    end
  end

  // Combinational read relative to the newest entry.
  always_comb begin
    rd_idx  = wr_ptr_q - AW'(1) - rd_age_i;
    rd_word = mem_q[rd_idx];
    rd_ok_o = ({1'b0, rd_age_i} < fill_q);
    rd_x_o  = rd_ok_o ? rd_word[X_W+Y_W-1:Y_W] : '0;
    rd_y_o  = rd_ok_o ? rd_word[Y_W-1:0]       : '0;
  end

endmodule

// File: rtl/swipe_detector.sv
// Per-frame motion stage: stage 1 computes frame-to-frame velocity and speed,
// stage 2 runs the swipe gesture FSM one cycle later. Centroid history for
// the overlay lives in com_history.
module swipe_detector
  import swipe_pkg::*;
#(
  parameter int HIST_DEPTH = 8,
  parameter int MIN_SPEED  = 24,
  parameter int MIN_FRAMES = 3,
  parameter int GAP_FRAMES = 4,
  localparam int AGE_W = $clog2(HIST_DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             frame_valid_i,
  input  logic [X_W-1:0]   com_x_i,
  input  logic [Y_W-1:0]   com_y_i,
  input  logic             com_present_i,
  input  logic [AGE_W-1:0] hist_age_i,
  output logic [VX_W-1:0]  vel_x_o,
  output logic [VY_W-1:0]  vel_y_o,
  output logic [SPD_W-1:0] speed_o,
  output logic             swipe_o,
  output logic [1:0]       swipe_dir_o,
  output logic [RUN_W-1:0] swipe_frames_o,
  output logic [X_W-1:0]   hist_x_o,
  output logic [Y_W-1:0]   hist_y_o,
  output logic             hist_ok_o
);

  localparam int GAP_W = (GAP_FRAMES < 2) ? 1 : $clog2(GAP_FRAMES + 1);

  // ---------------- Stage 1: velocity ----------------
  logic [X_W-1:0]   prev_x_q;
  logic [Y_W-1:0]   prev_y_q;
  logic             prev_present_q;
  logic [VX_W-1:0]  vel_x_q;
  logic [VY_W-1:0]  vel_y_q;
  logic [SPD_W-1:0] speed_q;
  logic             s1_valid_q;
  logic [X_W-1:0]   s1_prev_x_q, s1_cur_x_q;
  logic [Y_W-1:0]   s1_prev_y_q, s1_cur_y_q;

  logic [VX_W-1:0]  dx_c;
  logic [VY_W-1:0]  dy_c;
  logic [SPD_W-1:0] spd_c;
  logic             pair_c;

  // Zero-extended subtraction gives a correct signed delta in one extra bit.
  always_comb begin
    dx_c   = {1'b0, com_x_i} - {1'b0, prev_x_q};
    dy_c   = {1'b0, com_y_i} - {1'b0, prev_y_q};
    spd_c  = mag12(dx_c) + mag12({dy_c[VY_W-1], dy_c});
    pair_c = com_present_i & prev_present_q;
  end

  // Register velocity and forward both centroids to the gesture stage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_x_q       <= '0;
      prev_y_q       <= '0;
      prev_present_q <= 1'b0;
      vel_x_q        <= '0;
      vel_y_q        <= '0;
      speed_q        <= '0;
      s1_valid_q     <= 1'b0;
      s1_prev_x_q    <= '0;
      s1_prev_y_q    <= '0;
      s1_cur_x_q     <= '0;
      s1_cur_y_q     <= '0;
    end else begin
      s1_valid_q <= frame_valid_i;
      if (frame_valid_i) begin
        prev_x_q       <= com_x_i;
        prev_y_q       <= com_y_i;
        prev_present_q <= com_present_i;
        vel_x_q        <= pair_c ? dx_c  : '0;
        vel_y_q        <= pair_c ? dy_c  : '0;
        speed_q        <= pair_c ? spd_c : '0;
        s1_prev_x_q    <= prev_x_q;
        s1_prev_y_q    <= prev_y_q;
        s1_cur_x_q     <= com_x_i;
        s1_cur_y_q     <= com_y_i;
      end
    end
  end

  // ---------------- Stage 2: gesture FSM ----------------
  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [X_W-1:0]   start_x_q, start_x_d, end_x_q, end_x_d;
  logic [Y_W-1:0]   start_y_q, start_y_d, end_y_q, end_y_d;
  logic             swipe_q, swipe_d;
  logic [1:0]       dir_q, dir_d;
  logic [RUN_W-1:0] frames_q, frames_d;

  logic             moving_c;
  logic [VX_W-1:0]  nx_c;
  logic [VY_W-1:0]  ny_c;
  logic             horiz_c;
  logic [1:0]       net_dir_c;

  // Net displacement of the run; ties between axes resolve to horizontal.
  always_comb begin
    moving_c  = (speed_q >= SPD_W'(MIN_SPEED));
    nx_c      = {1'b0, end_x_q} - {1'b0, start_x_q};
    ny_c      = {1'b0, end_y_q} - {1'b0, start_y_q};
    horiz_c   = (mag12(nx_c) >= mag12({ny_c[VY_W-1], ny_c}));
    net_dir_c = horiz_c ? (nx_c[VX_W-1] ? DIR_LEFT : DIR_RIGHT)
                        : (ny_c[VY_W-1] ? DIR_UP   : DIR_DOWN);
  end

  // Next-state logic; advances only when stage 1 hands over a frame.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    gap_d     = gap_q;
    start_x_d = start_x_q;
    start_y_d = start_y_q;
    end_x_d   = end_x_q;
    end_y_d   = end_y_q;
    swipe_d   = 1'b0;
    dir_d     = dir_q;
    frames_d  = frames_q;
    if (s1_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (moving_c) begin
            start_x_d = s1_prev_x_q;
            start_y_d = s1_prev_y_q;
            end_x_d   = s1_cur_x_q;
            end_y_d   = s1_cur_y_q;
            run_d     = RUN_W'(1);
            state_d   = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (moving_c) begin
            if (run_q != '1) run_d = run_q + 1'b1;
            end_x_d = s1_cur_x_q;
            end_y_d = s1_cur_y_q;
          end else if (run_q >= RUN_W'(MIN_FRAMES)) begin
            swipe_d  = 1'b1;
            frames_d = run_q;
            dir_d    = net_dir_c;
            gap_d    = GAP_W'(GAP_FRAMES);
            state_d  = (GAP_FRAMES == 0) ? ST_IDLE : ST_COOLDOWN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_COOLDOWN: begin
          gap_d = gap_q - 1'b1;
          if (gap_q <= GAP_W'(1)) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Gesture state registers; reset abandons any run in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      run_q     <= '0;
      gap_q     <= '0;
      start_x_q <= '0;
      start_y_q <= '0;
      end_x_q   <= '0;
      end_y_q   <= '0;
      swipe_q   <= 1'b0;
      dir_q     <= DIR_RIGHT;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      gap_q     <= gap_d;
      start_x_q <= start_x_d;
      start_y_q <= start_y_d;
      end_x_q   <= end_x_d;
      end_y_q   <= end_y_d;
      swipe_q   <= swipe_d;
      dir_q     <= dir_d;
      frames_q  <= frames_d;
    end
  end

  // ---------------- History ----------------
  com_history #(.HIST_DEPTH(HIST_DEPTH)) u_hist (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .wr_en_i  (frame_valid_i),
    .wr_x_i   (com_x_i),
    .wr_y_i   (com_y_i),
    .rd_age_i (hist_age_i),
    .rd_x_o   (hist_x_o),
    .rd_y_o   (hist_y_o),
    .rd_ok_o  (hist_ok_o)
  );

  assign vel_x_o        = vel_x_q;
  assign vel_y_o        = vel_y_q;
  assign speed_o        = speed_q;
  assign swipe_o        = swipe_q;
  assign swipe_dir_o    = dir_q;
  assign swipe_frames_o = frames_q;

endmodule
